// File: rtl/fp_cmult_arbiter.sv
// -----------------------------------------------------------------------------
// fp_cmult_arbiter
//
// Shares one external fixed-point complex multiplier between NREQ requesters.
// A round-robin arbiter picks one requester at a time. Its operands are
// forwarded to the multiplier. The result is captured and returned on a shared
// result bus, qualified by a one-hot send_val. Only one job is in flight at a
// time.
//
// Parameters
//   n    : operand/result width (two's-complement fixed point)
//   d    : fractional bits (informational only; the multiplier does the scaling)
//   NREQ : number of requesters, 2..8
//
// Ports
//   clk, reset (async, active low)
//   recv_val/recv_rdy[NREQ]            : per-requester operand handshake
//   recv_ar/ac/br/bc[NREQ*n]           : packed operands, requester i at [i*n +: n]
//   send_val/send_rdy[NREQ]            : per-requester result handshake
//   cr, cc[n]                          : shared result bus (valid with send_val)
//   m_recv_val/m_recv_rdy, m_ar..m_bc  : operand handshake to the multiplier
//   m_send_val/m_send_rdy, m_cr, m_cc  : result handshake from the multiplier
// -----------------------------------------------------------------------------
module fp_cmult_arbiter #(
  parameter int n    = 32,
  parameter int d    = 16,
  parameter int NREQ = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   recv_val,
  output logic [NREQ-1:0]   recv_rdy,
  input  logic [NREQ*n-1:0] recv_ar,
  input  logic [NREQ*n-1:0] recv_ac,
  input  logic [NREQ*n-1:0] recv_br,
  input  logic [NREQ*n-1:0] recv_bc,
  output logic [NREQ-1:0]   send_val,
  input  logic [NREQ-1:0]   send_rdy,
  output logic [n-1:0]      cr,
  output logic [n-1:0]      cc,
  output logic              m_recv_val,
  input  logic              m_recv_rdy,
  output logic [n-1:0]      m_ar,
  output logic [n-1:0]      m_ac,
  output logic [n-1:0]      m_br,
  output logic [n-1:0]      m_bc,
  input  logic              m_send_val,
  output logic              m_send_rdy,
  input  logic [n-1:0]      m_cr,
  input  logic [n-1:0]      m_cc
);

  localparam int GW = $clog2(NREQ);

  // Elaboration-time parameter sanity checks.
  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("fp_cmult_arbiter: NREQ must be in 2..8");
  end
  if (d < 0 || d > n) begin : g_bad_d
    $error("fp_cmult_arbiter: d must be in 0..n");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   gnt_q, gnt_d;
  logic [GW-1:0]   rr_q, rr_d;
  logic [n-1:0]    cr_q, cr_d;
  logic [n-1:0]    cc_q, cc_d;

  // Unpacked view of the per-requester operand buses.
  logic [n-1:0] ar_arr [NREQ];
  logic [n-1:0] ac_arr [NREQ];
  logic [n-1:0] br_arr [NREQ];
  logic [n-1:0] bc_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign ar_arr[gi] = recv_ar[gi*n +: n];
    assign ac_arr[gi] = recv_ac[gi*n +: n];
    assign br_arr[gi] = recv_br[gi*n +: n];
    assign bc_arr[gi] = recv_bc[gi*n +: n];
  end

  // Round-robin pick: first valid index scanning rr_q, rr_q+1, ... modulo NREQ.
  // cand is one bit wider so the wrap works for non-power-of-two NREQ.
  logic [GW-1:0] pick;
  logic          found;
  logic [GW:0]   cand;

  always_comb begin
    pick  = rr_q;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_q} + (GW+1)'(k);
      if (cand >= (GW+1)'(NREQ)) begin
        cand = cand - (GW+1)'(NREQ);
      end
      if (!found && recv_val[cand[GW-1:0]]) begin
        pick  = cand[GW-1:0];
        found = 1'b1;
      end
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    rr_d       = rr_q;
    cr_d       = cr_q;
    cc_d       = cc_q;
    recv_rdy   = '0;
    send_val   = '0;
    m_recv_val = 1'b0;
    m_send_rdy = 1'b0;
    m_ar       = '0;
    m_ac       = '0;
    m_br       = '0;
    m_bc       = '0;

    case (state_q)
      ST_IDLE: begin
        if (found) begin
          gnt_d   = pick;
          state_d = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        // Straight pass-through of the granted requester's handshake.
        m_recv_val      = recv_val[gnt_q];
        recv_rdy[gnt_q] = m_recv_rdy;
        m_ar            = ar_arr[gnt_q];
        m_ac            = ac_arr[gnt_q];
        m_br            = br_arr[gnt_q];
        m_bc            = bc_arr[gnt_q];
        if (!recv_val[gnt_q]) begin
          // Requester withdrew: abandon the grant, keep the fairness pointer.
          state_d = ST_IDLE;
        end else if (m_recv_rdy) begin
          state_d = ST_BUSY;
          rr_d    = (gnt_q == GW'(NREQ-1)) ? '0 : gnt_q + GW'(1);
        end
      end

      ST_BUSY: begin
        m_send_rdy = 1'b1;
        if (m_send_val) begin
          cr_d    = m_cr;
          cc_d    = m_cc;
          state_d = ST_RESP;
        end
      end

      ST_RESP: begin
        send_val[gnt_q] = 1'b1;
        if (send_rdy[gnt_q]) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // The result bus always shows the last captured result.
  assign cr = cr_q;
  assign cc = cc_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      rr_q    <= '0;
      cr_q    <= '0;
      cc_q    <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      cr_q    <= cr_d;
      cc_q    <= cc_d;
    end
  end

endmodule

// File: tb/tb_fp_cmult_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fp_cmult_arbiter
//
// Directed bench for fp_cmult_arbiter with a behavioural complex multiplier
// (configurable latency, shared reset) attached to the m_* interface.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fp_cmult_arbiter;
  localparam int N  = 32;
  localparam int D  = 16;
  localparam int NR = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [NR-1:0]   recv_val, recv_rdy, send_val, send_rdy;
  logic [NR*N-1:0] recv_ar, recv_ac, recv_br, recv_bc;
  logic [N-1:0]    cr, cc, m_ar, m_ac, m_br, m_bc, m_cr, m_cc;
  logic            m_recv_val, m_recv_rdy, m_send_val, m_send_rdy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fp_cmult_arbiter #(.n(N), .d(D), .NREQ(NR)) dut (
    .clk        (clk),
    .reset      (reset),
    .recv_val   (recv_val),
    .recv_rdy   (recv_rdy),
    .recv_ar    (recv_ar),
    .recv_ac    (recv_ac),
    .recv_br    (recv_br),
    .recv_bc    (recv_bc),
    .send_val   (send_val),
    .send_rdy   (send_rdy),
    .cr         (cr),
    .cc         (cc),
    .m_recv_val (m_recv_val),
    .m_recv_rdy (m_recv_rdy),
    .m_ar       (m_ar),
    .m_ac       (m_ac),
    .m_br       (m_br),
    .m_bc       (m_bc),
    .m_send_val (m_send_val),
    .m_send_rdy (m_send_rdy),
    .m_cr       (m_cr),
    .m_cc       (m_cc)
  );

  // Fixed-point complex product {re, im} with D fractional bits.
  function automatic logic [2*N-1:0] cmul(input logic [N-1:0] ar, ac, br, bc);
    logic signed [63:0] re, im;
    re = longint'($signed(ar)) * longint'($signed(br)) - longint'($signed(ac)) * longint'($signed(bc));
    im = longint'($signed(ar)) * longint'($signed(bc)) + longint'($signed(ac)) * longint'($signed(br));
    return {re[N+D-1:D], im[N+D-1:D]};
  endfunction

  // Behavioural multiplier: result appears mul_lat edges after acceptance.
  logic mrdy_en;
  int   mul_lat;
  int   mul_accepts = 0;
  logic mul_busy;
  int   mul_cnt;

  assign m_recv_rdy = mrdy_en & ~mul_busy;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mul_busy   <= 1'b0;
      mul_cnt    <= 0;
      m_send_val <= 1'b0;
      m_cr       <= '0;
      m_cc       <= '0;
    end else if (!mul_busy) begin
      if (m_recv_val && m_recv_rdy) begin
        mul_busy     <= 1'b1;
        mul_cnt      <= mul_lat - 1;
        {m_cr, m_cc} <= cmul(m_ar, m_ac, m_br, m_bc);
        mul_accepts  <= mul_accepts + 1;
      end
    end else if (!m_send_val) begin
      if (mul_cnt == 0) m_send_val <= 1'b1;
      else              mul_cnt    <= mul_cnt - 1;
    end else if (m_send_rdy) begin
      m_send_val <= 1'b0;
      mul_busy   <= 1'b0;
    end
  end

  // ---------------------------------------------------------------- helpers
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    recv_val = '0;
    send_rdy = '0;
    recv_ar  = '0;
    recv_ac  = '0;
    recv_br  = '0;
    recv_bc  = '0;
  endtask

  task automatic do_reset;
    clear_inputs();
    mrdy_en = 1'b1;
    mul_lat = 2;
    reset   = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic set_ops(input int i, input logic [N-1:0] ar, ac, br, bc);
    recv_ar[i*N +: N] = ar;
    recv_ac[i*N +: N] = ac;
    recv_br[i*N +: N] = br;
    recv_bc[i*N +: N] = bc;
  endtask

  task automatic wait_send(output int waited, output bit ok);
    waited = 0;
    ok     = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (send_val != '0) begin
        ok = 1'b1;
        break;
      end
      tick();
      waited++;
    end
  endtask

  // Runs one complete job for requester idx and returns what the bus showed.
  task automatic run_job(input int idx, input logic [N-1:0] ar, ac, br, bc,
                         output logic [NR-1:0] sv, output logic [N-1:0] ocr, occ,
                         output bit ok);
    bit acc;
    int w;
    set_ops(idx, ar, ac, br, bc);
    recv_val[idx] = 1'b1;
    acc = 1'b0;
    ok  = 1'b0;
    sv  = '0;
    ocr = '0;
    occ = '0;
    for (int c = 0; c < 50 && !acc; c++) begin
      #1;
      acc = recv_rdy[idx];
      tick();
    end
    recv_val[idx] = 1'b0;
    if (acc) begin
      wait_send(w, ok);
      sv  = send_val;
      ocr = cr;
      occ = cc;
      send_rdy[idx] = 1'b1;
      tick();
      send_rdy[idx] = 1'b0;
    end
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset;
    clear_inputs();
    mrdy_en = 1'b1;
    mul_lat = 2;
    reset   = 1'b0;
    set_ops(0, 32'h1111_0000, 32'h2222_0000, 32'h3333_0000, 32'h4444_0000);
    recv_val = '1;
    send_rdy = '1;
    tick();
    tick();
    #1;
    checks++;
    if ({recv_rdy, send_val, m_recv_val, m_send_rdy} !== '0) begin
      failures++;
      $display("FAIL reset_handshakes got=%b exp=0", {recv_rdy, send_val, m_recv_val, m_send_rdy});
    end
    checks++;
    if ({cr, cc} !== '0) begin
      failures++;
      $display("FAIL reset_result got=%h_%h exp=0", cr, cc);
    end
    checks++;
    if ({m_ar, m_ac, m_br, m_bc} !== '0) begin
      failures++;
      $display("FAIL reset_m_ops got=%h exp=0", {m_ar, m_ac, m_br, m_bc});
    end
    recv_val = '0;
    send_rdy = '0;
    reset    = 1'b1;
    tick();
    tick();
    tick();
    checks++;
    if ({recv_rdy, m_recv_val} !== '0) begin
      failures++;
      $display("FAIL reset_idle_no_request got=%b exp=0", {recv_rdy, m_recv_val});
    end
  endtask

  task automatic test_single;
    int w;
    bit ok;
    do_reset();
    set_ops(2, 32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000);
    recv_val = 4'b0100;
    #1;
    checks++;
    if (recv_rdy !== 4'b0000) begin
      failures++;
      $display("FAIL single_idle_rdy got=%b exp=0000", recv_rdy);
    end
    tick();
    #1;
    checks++;
    if (m_recv_val !== 1'b1 || recv_rdy !== 4'b0100) begin
      failures++;
      $display("FAIL single_issue got=%b/%b exp=1/0100", m_recv_val, recv_rdy);
    end
    checks++;
    if (m_ar !== 32'h0001_0000 || m_ac !== 32'h0002_0000 || m_br !== 32'h0003_0000 || m_bc !== 32'h0004_0000) begin
      failures++;
      $display("FAIL single_mux got=%h %h %h %h exp=00010000 00020000 00030000 00040000", m_ar, m_ac, m_br, m_bc);
    end
    tick();
    recv_val = '0;
    wait_send(w, ok);
    checks++;
    if (!ok || w != 3) begin
      failures++;
      $display("FAIL single_latency got=%0d ok=%0d exp=3", w, ok);
    end
    checks++;
    if (send_val !== 4'b0100 || cr !== 32'hFFFB_0000 || cc !== 32'h000A_0000) begin
      failures++;
      $display("FAIL single_result got=%b %h %h exp=0100 fffb0000 000a0000", send_val, cr, cc);
    end
    send_rdy = 4'b1011;
    tick();
    checks++;
    if (send_val !== 4'b0100) begin
      failures++;
      $display("FAIL single_other_rdy_ignored got=%b exp=0100", send_val);
    end
    send_rdy = 4'b0100;
    tick();
    send_rdy = '0;
    checks++;
    if (send_val !== 4'b0000 || cr !== 32'hFFFB_0000 || cc !== 32'h000A_0000) begin
      failures++;
      $display("FAIL single_hold got=%b %h %h exp=0000 fffb0000 000a0000", send_val, cr, cc);
    end
  endtask

  task automatic test_round_robin;
    int order [5] = '{0, 1, 2, 3, 0};
    int w;
    bit ok;
    logic [NR-1:0] exp_sv;
    do_reset();
    // ar=i+1, ac=1, br=2, bc=1 -> re = 2i+1, im = i+3
    for (int i = 0; i < NR; i++) begin
      set_ops(i, N'((i + 1) << 16), 32'h0001_0000, 32'h0002_0000, 32'h0001_0000);
    end
    recv_val = '1;
    send_rdy = '1;
    for (int j = 0; j < 5; j++) begin
      wait_send(w, ok);
      exp_sv = NR'(1) << order[j];
      checks++;
      if (!ok || send_val !== exp_sv) begin
        failures++;
        $display("FAIL rr_order job=%0d got=%b exp=%b", j, send_val, exp_sv);
      end
      checks++;
      if (cr !== N'((2 * order[j] + 1) << 16) || cc !== N'((order[j] + 3) << 16)) begin
        failures++;
        $display("FAIL rr_result job=%0d got=%h %h exp=%h %h", j, cr, cc,
                 N'((2 * order[j] + 1) << 16), N'((order[j] + 3) << 16));
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_backpressure;
    int w;
    bit ok;
    int bad;
    do_reset();
    // 3.0 * 2.0 = 6.0 ; 3.0 * 0.5 = 1.5
    set_ops(1, 32'h0003_0000, 32'h0000_0000, 32'h0002_0000, 32'h0000_8000);
    recv_val = 4'b0010;
    tick();
    tick();
    recv_val = 4'b1101;
    send_rdy = 4'b1101;
    wait_send(w, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL bp_timeout got=none exp=send_val");
    end
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (send_val !== 4'b0010 || cr !== 32'h0006_0000 || cc !== 32'h0001_8000 ||
          m_recv_val !== 1'b0 || recv_rdy !== 4'b0000) begin
        failures++;
        $display("FAIL bp_stall cyc=%0d got=%b %h %h %b %b exp=0010 00060000 00018000 0 0000",
                 c, send_val, cr, cc, m_recv_val, recv_rdy);
      end
      tick();
    end
    send_rdy = 4'b0010;
    tick();
    checks++;
    if (send_val !== 4'b0000) begin
      failures++;
      $display("FAIL bp_release got=%b exp=0000", send_val);
    end
    send_rdy = '0;
    tick();
    #1;
    checks++;
    if (recv_rdy !== 4'b0100) begin
      failures++;
      $display("FAIL bp_next_grant got=%b exp=0100", recv_rdy);
    end
    clear_inputs();
  endtask

  task automatic test_reset_busy;
    logic [NR-1:0] sv;
    logic [N-1:0]  ocr, occ;
    bit ok;
    int acc0;
    logic seen;
    do_reset();
    run_job(0, 32'h0002_0000, 32'h0, 32'h0003_0000, 32'h0, sv, ocr, occ, ok);
    checks++;
    if (!ok || sv !== 4'b0001 || ocr !== 32'h0006_0000 || occ !== 32'h0) begin
      failures++;
      $display("FAIL rstb_first_job got=%b %h %h exp=0001 00060000 00000000", sv, ocr, occ);
    end
    mul_lat = 6;
    set_ops(1, 32'h0001_0000, 32'h0, 32'h0001_0000, 32'h0);
    recv_val = 4'b0010;
    for (int c = 0; c < 20 && m_send_rdy !== 1'b1; c++) tick();
    recv_val = '0;
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({send_val, recv_rdy, m_recv_val, m_send_rdy} !== '0 || {cr, cc} !== '0) begin
      failures++;
      $display("FAIL rstb_immediate got=%b %h %h exp=0 0 0",
               {send_val, recv_rdy, m_recv_val, m_send_rdy}, cr, cc);
    end
    tick();
    reset = 1'b1;
    acc0  = mul_accepts;
    seen  = 1'b0;
    for (int c = 0; c < 15; c++) begin
      if (send_val != '0 || m_send_rdy) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen !== 1'b0 || mul_accepts != acc0) begin
      failures++;
      $display("FAIL rstb_discard got=%b/%0d exp=0/%0d", seen, mul_accepts, acc0);
    end
    mul_lat = 2;
    run_job(3, 32'hFFFF_0000, 32'h0, 32'h0004_0000, 32'h0, sv, ocr, occ, ok);
    checks++;
    if (!ok || sv !== 4'b1000 || ocr !== 32'hFFFC_0000 || occ !== 32'h0) begin
      failures++;
      $display("FAIL rstb_new_job got=%b %h %h exp=1000 fffc0000 00000000", sv, ocr, occ);
    end
  endtask

  task automatic test_drop;
    logic [NR-1:0] sv;
    logic [N-1:0]  ocr, occ;
    bit ok;
    int acc0;
    int w;
    do_reset();
    run_job(0, 32'h0001_0000, 32'h0, 32'h0001_0000, 32'h0, sv, ocr, occ, ok);
    mrdy_en = 1'b0;
    acc0    = mul_accepts;
    set_ops(3, 32'h0005_0000, 32'h0, 32'h0005_0000, 32'h0);
    set_ops(2, 32'h0002_0000, 32'h0001_0000, 32'h0001_0000, 32'h0002_0000);
    recv_val = 4'b1000;
    tick();
    #1;
    checks++;
    if (m_recv_val !== 1'b1 || recv_rdy !== 4'b0000) begin
      failures++;
      $display("FAIL drop_issue got=%b/%b exp=1/0000", m_recv_val, recv_rdy);
    end
    recv_val = 4'b0101;
    #1;
    checks++;
    if (m_recv_val !== 1'b0) begin
      failures++;
      $display("FAIL drop_withdraw got=%b exp=0", m_recv_val);
    end
    tick();
    checks++;
    if (m_recv_val !== 1'b0 || recv_rdy !== 4'b0000) begin
      failures++;
      $display("FAIL drop_idle got=%b/%b exp=0/0000", m_recv_val, recv_rdy);
    end
    mrdy_en = 1'b1;
    tick();
    #1;
    checks++;
    if (recv_rdy !== 4'b0100 || mul_accepts != acc0) begin
      failures++;
      $display("FAIL drop_regrant got=%b/%0d exp=0100/%0d", recv_rdy, mul_accepts, acc0);
    end
    tick();
    recv_val = '0;
    wait_send(w, ok);
    // (2+1i)*(1+2i) = 0 + 5i
    checks++;
    if (!ok || send_val !== 4'b0100 || cr !== 32'h0 || cc !== 32'h0005_0000) begin
      failures++;
      $display("FAIL drop_result got=%b %h %h exp=0100 00000000 00050000", send_val, cr, cc);
    end
    send_rdy = 4'b0100;
    tick();
    clear_inputs();
  endtask

  task automatic test_random;
    logic [NR-1:0]  pend, infl, hs_r, hs_s;
    logic [N-1:0]   exp_cr [NR];
    logic [N-1:0]   exp_cc [NR];
    int             wait_jobs [NR];
    int             served [NR];
    int             jobs, max_wait, k, min_served;
    logic [2*N-1:0] r;
    do_reset();
    pend     = '0;
    infl     = '0;
    jobs     = 0;
    max_wait = 0;
    for (int i = 0; i < NR; i++) begin
      wait_jobs[i] = 0;
      served[i]    = 0;
      exp_cr[i]    = '0;
      exp_cc[i]    = '0;
    end
    for (int cyc = 0; cyc < 60000 && jobs < 1000; cyc++) begin
      for (int i = 0; i < NR; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          set_ops(i, $urandom, $urandom, $urandom, $urandom);
        end
      end
      recv_val = pend;
      send_rdy = NR'($urandom_range(0, (1 << NR) - 1));
      mrdy_en  = ($urandom_range(0, 3) != 0);
      mul_lat  = $urandom_range(1, 3);
      #2;
      hs_r = recv_val & recv_rdy;
      hs_s = send_val & send_rdy;
      for (int i = 0; i < NR; i++) begin
        if (hs_r[i]) begin
          r = cmul(recv_ar[i*N +: N], recv_ac[i*N +: N], recv_br[i*N +: N], recv_bc[i*N +: N]);
          exp_cr[i] = r[2*N-1:N];
          exp_cc[i] = r[N-1:0];
          infl[i]   = 1'b1;
          pend[i]   = 1'b0;
          if (wait_jobs[i] > max_wait) max_wait = wait_jobs[i];
          wait_jobs[i] = 0;
        end
      end
      if (hs_r != '0) begin
        for (int i = 0; i < NR; i++) if (pend[i]) wait_jobs[i]++;
      end
      if (hs_s != '0) begin
        k = 0;
        for (int i = 0; i < NR; i++) if (hs_s[i]) k = i;
        checks++;
        if (!$onehot(send_val) || !infl[k] || cr !== exp_cr[k] || cc !== exp_cc[k]) begin
          failures++;
          $display("FAIL random_result job=%0d req=%0d got=%b %h %h exp=one-hot %h %h",
                   jobs, k, send_val, cr, cc, exp_cr[k], exp_cc[k]);
        end
        infl[k] = 1'b0;
        served[k]++;
        jobs++;
      end
      tick();
    end
    clear_inputs();
    checks++;
    if (jobs != 1000) begin
      failures++;
      $display("FAIL random_job_count got=%0d exp=1000", jobs);
    end
    checks++;
    if (max_wait > NR - 1) begin
      failures++;
      $display("FAIL random_starvation got=%0d exp<=%0d", max_wait, NR - 1);
    end
    min_served = served[0];
    for (int i = 1; i < NR; i++) if (served[i] < min_served) min_served = served[i];
    checks++;
    if (min_served == 0) begin
      failures++;
      $display("FAIL random_all_served got=%0d exp>0", min_served);
    end
  endtask

  initial begin
    reset = 1'b0;
    clear_inputs();
    mrdy_en = 1'b1;
    mul_lat = 2;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_reset_busy();
    test_drop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
